// File: rtl/dct_mac_unit.sv
// Multiply-accumulate for one forward-DCT coefficient: N signed sample*coef terms -> rounded, saturated result.
// Latency: result strobe appears 2 enabled cycles after the last term is presented.
// No backpressure: ena=0 freezes all state (douten drops low); dstrb mid-block restarts and drops the partial block.
module dct_mac_unit #(
   parameter int DW    = 8,
   parameter int CW    = 12,
   parameter int N     = 8,
   parameter int SHIFT = 8,
   parameter int OW    = 12,
   parameter int ROUND = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 dstrb,
   input  logic signed [DW-1:0] din,
   input  logic signed [CW-1:0] coef,
   output logic signed [OW-1:0] dout,
   output logic                 douten
);

   localparam int AW = DW + CW + $clog2(N);
   localparam int PW = DW + CW;
   localparam int TW = $clog2(N);

   // Rounding bias and saturation limits, one bit wider than the accumulator
   // so adding the bias can never wrap.
   localparam logic signed [AW:0] C_RND = (ROUND != 0) ? (AW+1)'(2**(SHIFT-1)) : '0;
   localparam logic signed [AW:0] C_MAX = (AW+1)'(2**(OW-1) - 1);
   localparam logic signed [AW:0] C_MIN = -C_MAX - (AW+1)'(1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                r_state;
   logic [TW-1:0]         r_term;      // index of the term expected on the next enabled cycle
   logic signed [PW-1:0]  r_mult;
   logic                  r_vld;
   logic                  r_first;
   logic                  r_last;
   logic signed [AW-1:0]  r_acc;
   logic signed [OW-1:0]  r_dout;
   logic                  r_douten;

   logic                  w_take;
   logic [TW-1:0]         w_term;
   logic                  w_last;
   logic signed [PW-1:0]  w_prod;
   logic signed [AW-1:0]  w_mult_ext;
   logic signed [AW-1:0]  w_sum;
   logic signed [AW:0]    w_rnd;
   logic signed [AW:0]    w_shift;
   logic signed [OW-1:0]  w_sat;

   // A term is taken whenever a block is running or a new one starts; dstrb
   // always forces term index 0, which is how a restart discards the old block.
   assign w_take = dstrb | (r_state == S_RUN);
   assign w_term = dstrb ? '0 : r_term;
   assign w_last = w_take && (w_term == TW'(N-1));

   // Full-precision signed product: both operands widened before multiplying.
   assign w_prod = PW'(din) * PW'(coef);

   // Final sum uses the accumulator plus the product still in stage 1 of the
   // last term, so the result registers one enabled edge after that term.
   assign w_mult_ext = AW'(r_mult);
   assign w_sum      = r_acc + w_mult_ext;
   assign w_rnd      = (AW+1)'(w_sum) + C_RND;
   assign w_shift    = w_rnd >>> SHIFT;

   // Clamp the shifted sum into the signed output range.
   always_comb begin
      w_sat = w_shift[OW-1:0];
      if (w_shift > C_MAX)
         w_sat = C_MAX[OW-1:0];
      else if (w_shift < C_MIN)
         w_sat = C_MIN[OW-1:0];
   end

   // Block sequencer: tracks which term of the current block arrives next.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_term  <= '0;
      end else if (ena) begin
         if (dstrb) begin
            r_state <= S_RUN;
            r_term  <= TW'(1);
         end else if (r_state == S_RUN) begin
            if (r_term == TW'(N-1)) begin
               r_state <= S_IDLE;
               r_term  <= '0;
            end else begin
               r_term  <= r_term + TW'(1);
            end
         end
      end
   end

   // Stage 1: registered product with its first/last/valid tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mult  <= '0;
         r_vld   <= 1'b0;
         r_first <= 1'b0;
         r_last  <= 1'b0;
      end else if (ena) begin
         r_mult  <= w_prod;
         r_vld   <= w_take;
         r_first <= dstrb;
         r_last  <= w_last;
      end
   end

   // Stage 2: accumulate and, on the last tag, register the scaled result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc    <= '0;
         r_dout   <= '0;
         r_douten <= 1'b0;
      end else if (ena) begin
         r_douten <= 1'b0;
         if (r_vld) begin
            r_acc <= r_first ? w_mult_ext : w_sum;
            if (r_last) begin
               r_dout   <= w_sat;
               r_douten <= 1'b1;
            end
         end
      end else begin
         r_douten <= 1'b0;
      end
   end

   assign dout   = r_dout;
   assign douten = r_douten;

endmodule

// File: tb/tb_dct_mac_unit.sv
// Scoreboard bench for dct_mac_unit: two instances (ROUND=1 and ROUND=0) share stimulus.
// Expected results and their enabled-edge arrival time are queued when a block's last term is driven.
// Outputs are sampled on the falling edge; every douten pulse pops and compares one entry.
module tb_dct_mac_unit;

   localparam int N = 8;

   logic clk = 1'b0;
   logic rst, ena, dstrb;
   logic signed [7:0]  din;
   logic signed [11:0] coef;
   logic signed [11:0] dout1, dout0;
   logic               douten1, douten0;

   always #5 clk = ~clk;

   dct_mac_unit #(.DW(8), .CW(12), .N(N), .SHIFT(8), .OW(12), .ROUND(1)) u_r1 (
      .clk(clk), .rst(rst), .ena(ena), .dstrb(dstrb), .din(din), .coef(coef),
      .dout(dout1), .douten(douten1));

   dct_mac_unit #(.DW(8), .CW(12), .N(N), .SHIFT(8), .OW(12), .ROUND(0)) u_r0 (
      .clk(clk), .rst(rst), .ena(ena), .dstrb(dstrb), .din(din), .coef(coef),
      .dout(dout0), .douten(douten0));

   typedef struct {
      int val;
      int t;
   } exp_t;

   exp_t q1[$];
   exp_t q0[$];
   int   n_chk  = 0;
   int   n_err  = 0;
   int   en_cnt = 0;
   int   dv[N];
   int   cv[N];

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference result: sum, optional half-LSB bias, floor shift, clamp.
   function automatic int model(input longint s, input int rnd);
      longint t;
      t = (s + (rnd != 0 ? 64'sd128 : 64'sd0)) >>> 8;
      if (t > 2047)  t = 2047;
      if (t < -2048) t = -2048;
      return int'(t);
   endfunction

   // Count enabled edges; latency is measured in these.
   always @(posedge clk) begin
      if (ena) en_cnt++;
   end

   // Output monitors.
   always @(negedge clk) begin
      exp_t e;
      if (douten1) begin
         if (q1.size() == 0) chk("r1_spurious_douten", 1, 0);
         else begin
            e = q1.pop_front();
            chk("r1_dout", dout1, e.val);
            chk("r1_latency", en_cnt, e.t);
         end
      end
      if (douten0) begin
         if (q0.size() == 0) chk("r0_spurious_douten", 1, 0);
         else begin
            e = q0.pop_front();
            chk("r0_dout", dout0, e.val);
            chk("r0_latency", en_cnt, e.t);
         end
      end
   end

   task automatic set_const(input int d, input int c);
      for (int i = 0; i < N; i++) begin
         dv[i] = d;
         cv[i] = c;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         ena   = 1'b1;
         dstrb = 1'b0;
         din   = 8'(-7);
         coef  = 12'(300);
      end
   endtask

   // Drive n terms from dv/cv (dstrb on the first); optional ena=0 gap before
   // term gap_at. Full blocks queue their expected results.
   task automatic drive_blk(input int n, input int gap_at, input int gap_len);
      longint s = 0;
      exp_t   e;
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            repeat (gap_len) begin
               @(negedge clk);
               ena   = 1'b0;
               dstrb = 1'b0;
               din   = 8'($urandom);
               coef  = 12'($urandom);
            end
         end
         @(negedge clk);
         ena   = 1'b1;
         dstrb = (i == 0);
         din   = 8'(dv[i]);
         coef  = 12'(cv[i]);
         s     = s + longint'(dv[i]) * longint'(cv[i]);
         if (i == N-1) begin
            e.t   = en_cnt + 2;
            e.val = model(s, 1);
            q1.push_back(e);
            e.val = model(s, 0);
            q0.push_back(e);
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      ena   = 1'b0;
      dstrb = 1'b0;
      din   = '0;
      coef  = '0;
      repeat (3) @(negedge clk);
      chk("reset_dout_r1", dout1, 0);
      chk("reset_douten_r1", douten1, 0);
      chk("reset_dout_r0", dout0, 0);
      chk("reset_douten_r0", douten0, 0);
      rst = 1'b0;
      idle(2);

      // Nominal: 8 x 10*256 -> 80
      set_const(10, 256);  drive_blk(8, -1, 0); idle(4);
      // Rounding: sum 128 -> 1 (round) / 0 (floor)
      set_const(1, 16);    drive_blk(8, -1, 0); idle(4);
      // Saturation both ways
      set_const(100, 2047);  drive_blk(8, -1, 0); idle(4);
      set_const(-100, 2047); drive_blk(8, -1, 0); idle(4);
      // Negative floor: -128 -> -1 (floor) / 0 (round)
      set_const(-1, 16);   drive_blk(8, -1, 0); idle(4);
      // Mixed-sign random block
      for (int i = 0; i < N; i++) begin
         dv[i] = int'($urandom_range(255)) - 128;
         cv[i] = int'($urandom_range(4095)) - 2048;
      end
      drive_blk(8, -1, 0); idle(4);

      // Restart: 5 aborted terms, then two back-to-back full blocks
      set_const(50, 256);  drive_blk(5, -1, 0);
      set_const(10, 256);  drive_blk(8, -1, 0);
      set_const(20, 256);  drive_blk(8, -1, 0);
      idle(4);

      // ena gap of 3 cycles mid-block
      set_const(10, 256);  drive_blk(8, 4, 3); idle(2);
      // ena gap straddling the output stage
      drive_blk(8, -1, 0);
      repeat (2) begin
         @(negedge clk);
         ena = 1'b0;
      end
      idle(4);

      // Reset at term 4 of a block
      set_const(10, 256);  drive_blk(4, -1, 0);
      @(negedge clk);
      rst   = 1'b1;
      ena   = 1'b1;
      dstrb = 1'b0;
      din   = 8'(10);
      coef  = 12'(256);
      @(negedge clk);
      chk("midrst_dout_r1", dout1, 0);
      chk("midrst_douten_r1", douten1, 0);
      chk("midrst_dout_r0", dout0, 0);
      rst = 1'b0;
      idle(6);
      drive_blk(8, -1, 0);
      idle(6);

      chk("r1_queue_drained", q1.size(), 0);
      chk("r0_queue_drained", q0.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
